// File: rtl/atm_pkg.sv
// Shared types and default constants for the ATM cash-dispense arbiter.
// Optional dispense timeout is enabled by defining DISP_TIMEOUT_EN.
package atm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    DONE,
    REJECT
  } disp_state_t;

  localparam int N_REQ_DEF         = 4;
  localparam int AMT_W_DEF         = 8;
  localparam int CASSETTE_INIT_DEF = 200;
  localparam int TIMEOUT_CYC_DEF   = 64;
  localparam int NOTES_W           = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
// The pointer itself is owned by the parent.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        idx    = IDX_W'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cash_dispense_arbiter.sv
// Round-robin owner of the shared note dispenser, one note per req/ack.
// Define DISP_TIMEOUT_EN to abort a stalled dispense with a fault pulse.
module cash_dispense_arbiter
  import atm_pkg::*;
#(
  parameter int N_REQ         = N_REQ_DEF,
  parameter int AMT_W         = AMT_W_DEF,
  parameter int CASSETTE_INIT = CASSETTE_INIT_DEF,
  parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*AMT_W-1:0] req_amount,
  input  logic               reload,
  output logic               note_req,
  input  logic               note_ack,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   reject,
  output logic               fault,
  output logic [NOTES_W-1:0] notes_left,
  output logic               busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [NOTES_W-1:0] NOTES_INIT = NOTES_W'(CASSETTE_INIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  disp_state_t        state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic [NOTES_W-1:0] notes_q, notes_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               rej_wait_q, rej_wait_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [AMT_W-1:0]   amt_sel;
  logic [IDX_W-1:0]   ptr_next;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign amt_sel  = req_amount[int'(arb_idx)*AMT_W +: AMT_W];
  assign ptr_next = (winner_q == LAST_IDX) ? '0 : winner_q + IDX_W'(1);

`ifdef DISP_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_q, tmo_d;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    remaining_d = remaining_q;
    notes_d     = notes_q;
    grant_d     = grant_q;
    rej_wait_d  = rej_wait_q;
`ifdef DISP_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_d       = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (reload) begin
          notes_d = NOTES_INIT;
        end else if (arb_valid) begin
          winner_d    = arb_idx;
          remaining_d = amt_sel;
          grant_d     = arb_gnt;
          if (amt_sel == '0 ||
              32'(amt_sel) > 32'(notes_q)) begin
            state_d    = REJECT;
            rej_wait_d = 1'b1;
          end else begin
            state_d = DISPENSE;
`ifdef DISP_TIMEOUT_EN
            tmo_cnt_d = '0;
            tmo_d     = 1'b0;
`endif
          end
        end
      end
      DISPENSE: begin
        if (note_ack) begin
          remaining_d = remaining_q - AMT_W'(1);
          notes_d     = notes_q - NOTES_W'(1);
          if (remaining_q == AMT_W'(1)) state_d = DONE;
`ifdef DISP_TIMEOUT_EN
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
        end
      end
      DONE: begin
        grant_d  = '0;
        rr_ptr_d = ptr_next;
        state_d  = IDLE;
`ifdef DISP_TIMEOUT_EN
        tmo_d    = 1'b0;
`endif
      end
      REJECT: begin
        // First cycle holds the grant; the pulse goes out on the second
        if (rej_wait_q) begin
          rej_wait_d = 1'b0;
        end else begin
          grant_d  = '0;
          rr_ptr_d = ptr_next;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      remaining_q <= '0;
      notes_q     <= NOTES_INIT;
      grant_q     <= '0;
      rej_wait_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      remaining_q <= remaining_d;
      notes_q     <= notes_d;
      grant_q     <= grant_d;
      rej_wait_q  <= rej_wait_d;
    end
  end

`ifdef DISP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign fault = (state_q == DONE) && tmo_q;
`else
  assign fault = 1'b0;
`endif

  assign note_req   = (state_q == DISPENSE);
  assign grant      = grant_q;
  assign done       = (state_q == DONE) ? grant_q : '0;
  assign reject     = (state_q == REJECT && !rej_wait_q) ? grant_q : '0;
  assign notes_left = notes_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cash_dispense_arbiter.sv
// Directed plus randomized bench for cash_dispense_arbiter.
// Reference model tracks cassette, pointer and expected transaction shape.
module tb_cash_dispense_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int INIT = 200;
  localparam int TMO  = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*AW-1:0] req_amount;
  logic          reload;
  logic          note_req;
  logic          note_ack;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic [N-1:0]  reject;
  logic          fault;
  logic [15:0]   notes_left;
  logic          busy;

  cash_dispense_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_amount (req_amount),
    .reload     (reload),
    .note_req   (note_req),
    .note_ack   (note_ack),
    .grant      (grant),
    .done       (done),
    .reject     (reject),
    .fault      (fault),
    .notes_left (notes_left),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int m_notes;
  int m_ptr;
  int served[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int w);
    logic [N-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  function automatic int pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  function automatic logic [N*AW-1:0] amts_all(input int a);
    logic [N*AW-1:0] v;
    for (int i = 0; i < N; i++) v[i*AW +: AW] = AW'(a);
    return v;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_nreq"}, note_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rej"}, reject, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_notes"}, notes_left, INIT);
  endtask

  // mode: 0 ack always, 1 ack toggling from 1, 2 random ack
  task automatic run_txn(input logic [N-1:0] r,
                         input logic [N*AW-1:0] amts,
                         input int mode,
                         input bit scramble);
    int w, amt, acks, cyc;
    bit acc;
    w   = pick(r);
    amt = int'(amts[w*AW +: AW]);
    acc = (amt != 0) && (amt <= m_notes);
    req = r;
    req_amount = amts;
    reload = 1'b0;
    note_ack = 1'b0;
    step();
    chk("grant_t1", grant, oh(w));
    chk("busy_t1", busy, 1);
    chk("notes_t1", notes_left, m_notes);
    if (scramble) begin
      req = N'($urandom);
      req_amount = (N*AW)'($urandom);
      reload = 1'($urandom);
    end
    if (!acc) begin
      chk("rej_nreq", note_req, 0);
      chk("rej_early", reject, 0);
      step();
      chk("reject", reject, oh(w));
      chk("rej_grant", grant, oh(w));
      chk("rej_nreq2", note_req, 0);
      chk("rej_notes", notes_left, m_notes);
      step();
      chk("rej_idle", busy, 0);
      chk("rej_gclr", grant, 0);
      chk("rej_pulse", reject, 0);
    end else begin
      acks = 0;
      cyc = 0;
      while (acks < amt && cyc < 2000) begin
        chk("nreq", note_req, 1);
        chk("no_done", done, 0);
        case (mode)
          0: note_ack = 1'b1;
          1: note_ack = (cyc % 2 == 0);
          default: note_ack = 1'($urandom);
        endcase
        step();
        if (note_ack) begin
          acks++;
          m_notes--;
        end
        note_ack = 1'b0;
        cyc++;
        chk("notes_dec", notes_left, m_notes);
      end
      chk("ack_budget", acks, amt);
      if (mode == 0) chk("nreq_cycles", cyc, amt);
      if (mode == 1) chk("tog_cycles", cyc, 2 * amt - 1);
      chk("done", done, oh(w));
      chk("done_nreq", note_req, 0);
      chk("done_grant", grant, oh(w));
      step();
      chk("done_idle", busy, 0);
      chk("done_gclr", grant, 0);
      chk("done_pulse", done, 0);
    end
    m_ptr = (w + 1) % N;
    served.push_back(w);
  endtask

  initial begin
    int exp_rr[4];
    logic [N*AW-1:0] a;
    logic [N-1:0] r;
    rst_n = 1'b0;
    req = '0;
    req_amount = '0;
    reload = 1'b0;
    note_ack = 1'b0;
    m_notes = INIT;
    m_ptr = 0;
    #12;
    chk_reset_outs("rst");
    @(negedge clk) rst_n = 1'b1;
    step();
    chk_reset_outs("post_rst");

    // single requester, 3 notes
    a = '0;
    a[2*AW +: AW] = 8'd3;
    run_txn(4'b0100, a, 0, 1'b0);
    chk("notes_197", notes_left, 197);

    // round robin from pointer 0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_notes = INIT;
    m_ptr = 0;
    served.delete();
    for (int i = 0; i < 4; i++) run_txn(4'b1011, amts_all(1), 0, 1'b0);
    exp_rr[0] = 0;
    exp_rr[1] = 1;
    exp_rr[2] = 3;
    exp_rr[3] = 0;
    for (int i = 0; i < 4; i++) chk("rr_order", served[i], exp_rr[i]);

    // drain to 5 notes, then reject cases and exact-fit
    run_txn(4'b0001, amts_all(m_notes - 5), 0, 1'b0);
    chk("notes_5", notes_left, 5);
    run_txn(4'b0010, amts_all(6), 0, 1'b0);
    run_txn(4'b0010, amts_all(0), 0, 1'b0);
    run_txn(4'b0010, amts_all(5), 0, 1'b0);
    chk("notes_0", notes_left, 0);

    // reload wins over a same-cycle request
    req = 4'b0001;
    req_amount = amts_all(4);
    reload = 1'b1;
    step();
    chk("reload_notes", notes_left, INIT);
    chk("reload_nogrant", grant, 0);
    chk("reload_idle", busy, 0);
    m_notes = INIT;
    run_txn(4'b0001, amts_all(4), 1, 1'b0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        req = '0;
        reload = 1'b1;
        step();
        reload = 1'b0;
        m_notes = INIT;
        chk("rnd_reload", notes_left, INIT);
      end
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        a[i*AW +: AW] = AW'($urandom_range(0, 14));
      run_txn(r, a, $urandom_range(0, 2), 1'b1);
    end
    req = '0;
    reload = 1'b0;

    // asynchronous reset in the middle of a dispense
    req = 4'b0001;
    req_amount = amts_all(10);
    step();
    req = '0;
    note_ack = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    note_ack = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    m_notes = INIT;
    m_ptr = 0;
    step();

    // ack stuck low
    req = 4'b0010;
    req_amount = amts_all(2);
    step();
    req = '0;
    chk("stk_grant", grant, 4'b0010);
`ifdef DISP_TIMEOUT_EN
    for (int c = 0; c < TMO; c++) begin
      chk("stk_nreq", note_req, 1);
      chk("stk_nofault", fault, 0);
      step();
    end
    chk("tmo_fault", fault, 1);
    chk("tmo_done", done, 4'b0010);
    chk("tmo_notes", notes_left, m_notes);
    step();
    chk("tmo_idle", busy, 0);
    chk("tmo_fclr", fault, 0);
`else
    for (int c = 0; c < TMO + 6; c++) step();
    chk("stk_busy", busy, 1);
    chk("stk_nreq", note_req, 1);
    chk("stk_fault", fault, 0);
    chk("stk_done", done, 0);
    note_ack = 1'b1;
    step();
    step();
    note_ack = 1'b0;
    m_notes -= 2;
    chk("stk_done2", done, 4'b0010);
    chk("stk_notes", notes_left, m_notes);
    step();
    chk("stk_idle", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
